// File: rtl/hop_lane_driver_chk_pkg.sv
// Shared types and LFSR constants for the hop-lane stimulus driver/checker.
package hop_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Fibonacci step for x^16+x^14+x^13+x^11+1: shift left, XOR of taps enters at bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/hop_lane_driver_chk_lfsr.sv
// 16-bit pattern LFSR with synchronous reload to the seed and an advance enable.
module hop_lfsr16
  import hop_chk_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_advance,
  output logic [15:0] o_state,
  output logic [15:0] o_next
);

  logic [15:0] r_state;

  assign o_next  = lfsr_step(r_state);
  assign o_state = r_state;

  // Load has priority so a restart always begins from the seed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= LFSR_SEED;
    end else if (i_load) begin
      r_state <= LFSR_SEED;
    end else if (i_advance) begin
      r_state <= o_next;
    end else begin
      r_state <= r_state;
    end
  end

endmodule

// File: rtl/hop_lane_driver_chk.sv
// Drives a pseudo-random lane pattern into a hop chain and checks that each
// vector reappears on lane_in exactly HOPS cycles after it was launched.
module hop_lane_driver_chk
  import hop_chk_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int HOPS        = 3,
  parameter int PATTERN_LEN = 16,
  parameter int ERR_W       = 8
) (
  input  logic             clock0,
  input  logic             rst1,
  input  logic             go,
  input  logic [LANES-1:0] lane_in,
  output logic [LANES-1:0] start_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [LANES-1:0] err_lane
);

  localparam logic [15:0] LAST_RUN   = 16'(PATTERN_LEN - 1);
  localparam logic [15:0] LAST_DRAIN = 16'(HOPS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_cnt;
  logic [15:0]      w_cnt_nxt;
  logic             w_start;
  logic             w_advance;
  logic [15:0]      w_lfsr_state;
  logic [15:0]      w_lfsr_next;
  logic [15:0]      w_launch;
  logic [LANES-1:0] w_so_nxt;
  logic [LANES-1:0] r_dly_vec [HOPS];
  logic [HOPS-1:0]  r_dly_v;
  logic [LANES-1:0] w_mism;
  logic [ERR_W-1:0] w_err_nxt;
  logic [LANES-1:0] w_lane_nxt;
  logic             w_unused_lfsr;

  hop_lfsr16 u_lfsr (
    .i_clk     (clock0),
    .i_rst     (rst1),
    .i_load    (w_start),
    .i_advance (w_advance),
    .o_state   (w_lfsr_state),
    .o_next    (w_lfsr_next)
  );

  // The launch that accompanies the go edge is the seed itself; later launches
  // take the step ahead of the LFSR so start_out and the LFSR stay in lockstep.
  assign w_launch      = w_start ? LFSR_SEED : w_lfsr_next;
  assign w_unused_lfsr = ^{w_lfsr_state, w_launch};

  // State register.
  always_ff @(posedge clock0 or posedge rst1) begin
    if (rst1) begin
      r_state <= IDLE;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, phase counter and LFSR control.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start     = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (go) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = 16'd0;
          w_start     = 1'b1;
        end else begin
          w_cnt_nxt = 16'd0;
        end
      end
      RUN: begin
        w_advance = 1'b1;
        if (r_cnt == LAST_RUN) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = 16'd0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      DRAIN: begin
        if (r_cnt == LAST_DRAIN) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = 16'd0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  // Launch data and tail-of-delay-line comparison.
  always_comb begin
    w_so_nxt   = '0;
    w_mism     = '0;
    w_err_nxt  = err_count;
    w_lane_nxt = err_lane;
    if (w_state_nxt == RUN) begin
      w_so_nxt = w_launch[LANES-1:0];
    end else begin
      w_so_nxt = '0;
    end
    if (r_dly_v[HOPS-1]) begin
      w_mism = lane_in ^ r_dly_vec[HOPS-1];
    end else begin
      w_mism = '0;
    end
    if (w_start) begin
      w_err_nxt  = '0;
      w_lane_nxt = '0;
    end else begin
      w_lane_nxt = err_lane | w_mism;
      if ((w_mism != '0) && (err_count != '1)) begin
        w_err_nxt = err_count + ERR_W'(1);
      end else begin
        w_err_nxt = err_count;
      end
    end
  end

  // Registered outputs; done/pass follow the next state so they rise on the
  // same edge that retires the final comparison.
  always_ff @(posedge clock0 or posedge rst1) begin
    if (rst1) begin
      start_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      err_lane  <= '0;
    end else begin
      start_out <= w_so_nxt;
      busy      <= (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
      done      <= (w_state_nxt == DONE);
      pass      <= (w_state_nxt == DONE) && (w_err_nxt == '0);
      err_count <= w_err_nxt;
      err_lane  <= w_lane_nxt;
    end
  end

  // Delay line: start_out is valid exactly while the FSM sits in RUN.
  always_ff @(posedge clock0 or posedge rst1) begin
    if (rst1) begin
      r_dly_v <= '0;
      for (int i = 0; i < HOPS; i++) begin
        r_dly_vec[i] <= '0;
      end
    end else if (w_start) begin
      r_dly_v <= '0;
      for (int i = 0; i < HOPS; i++) begin
        r_dly_vec[i] <= '0;
      end
    end else begin
      r_dly_v      <= {r_dly_v[HOPS-1:0], (r_state == RUN)} >> 0;
      r_dly_vec[0] <= start_out;
      for (int i = 1; i < HOPS; i++) begin
        r_dly_vec[i] <= r_dly_vec[i-1];
      end
    end
  end

endmodule

// File: tb/tb_hop_lane_driver_chk.sv
// Self-checking bench: loopback chain models with fault injection, compared
// against a pattern-level reference model.
module tb_hop_lane_driver_chk;

  localparam int LANES = 4;
  localparam int HOPS  = 3;
  localparam int PL    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       go_a = 1'b0;
  logic [3:0] lane_a, so_a, el_a;
  logic       busy_a, done_a, pass_a;
  logic [7:0] err_a;

  logic       go_b = 1'b0;
  logic [3:0] lane_b, so_b, el_b;
  logic       busy_b, done_b, pass_b;
  logic [1:0] err_b;

  int passed = 0;
  int total  = 0;

  hop_lane_driver_chk #(.LANES(LANES), .HOPS(HOPS), .PATTERN_LEN(PL), .ERR_W(8)) dut_a (
    .clock0(clk), .rst1(rst), .go(go_a), .lane_in(lane_a), .start_out(so_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .err_lane(el_a)
  );

  hop_lane_driver_chk #(.LANES(LANES), .HOPS(HOPS), .PATTERN_LEN(PL), .ERR_W(2)) dut_b (
    .clock0(clk), .rst1(rst), .go(go_b), .lane_in(lane_b), .start_out(so_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .err_lane(el_b)
  );

  // Loopback chains: register delays with optional stuck/inverted lanes.
  logic [3:0] hist_a [8];
  logic [3:0] hist_b [8];
  int         dly_a      = HOPS;
  logic [3:0] stuck_a    = 4'h0;
  logic [3:0] noise_a    = 4'h0;
  logic       noise_en_a = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        hist_a[i] <= 4'h0;
        hist_b[i] <= 4'h0;
      end
    end else begin
      hist_a[0] <= so_a;
      hist_b[0] <= so_b;
      for (int i = 1; i < 8; i++) begin
        hist_a[i] <= hist_a[i-1];
        hist_b[i] <= hist_b[i-1];
      end
    end
  end

  assign lane_a = noise_en_a ? noise_a : (hist_a[dly_a-1] & ~stuck_a);
  assign lane_b = ~hist_b[HOPS-1];

  // Reference: k-th launched vector, computed from the seed by repeated shifting.
  function automatic logic [3:0] vec(input int k);
    logic [15:0] s;
    s = 16'hACE1;
    for (int i = 0; i < k; i++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    return s[3:0];
  endfunction

  // Reference: vector k is checked against what the chain shows lag cycles late.
  function automatic void model(input int n_vec, input int lag, input logic [3:0] stuck,
                                input logic [3:0] inv, input int errw,
                                output int cnt, output logic [3:0] lanes);
    logic [3:0] raw, obs, mm;
    cnt   = 0;
    lanes = 4'h0;
    for (int k = 0; k < n_vec; k++) begin
      raw = (k - lag >= 0) ? vec(k - lag) : 4'h0;
      obs = (raw & ~stuck) ^ inv;
      mm  = obs ^ vec(k);
      if (mm != 4'h0) cnt++;
      lanes |= mm;
    end
    if (cnt > (1 << errw) - 1) cnt = (1 << errw) - 1;
  endfunction

  // Launch a run on dut_a and record what it does; g1/g2 inject go mid-run.
  task automatic run_a(input int g1, input int g2, output int busy_n, output logic [3:0] first_so,
                       output logic f_done, output logic [7:0] f_err, output logic [3:0] f_el,
                       output int seq_bad, output bit timed_out);
    logic [3:0] exp_so;
    @(negedge clk);
    go_a = 1'b1;
    @(negedge clk);
    go_a     = 1'b0;
    first_so = so_a;
    f_done   = done_a;
    f_err    = err_a;
    f_el     = el_a;
    busy_n   = 0;
    seq_bad  = 0;
    for (int c = 0; c < 200 && busy_a; c++) begin
      busy_n++;
      exp_so = (c < PL) ? vec(c) : 4'h0;
      if (so_a !== exp_so) seq_bad++;
      go_a = (c == g1) || (c == g2);
      @(negedge clk);
    end
    go_a      = 1'b0;
    timed_out = busy_a;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++; if (so_a !== 4'h0) $display("FAIL reset_start_out got=%h exp=0", so_a); else passed++;
    total++; if (busy_a !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_a); else passed++;
    total++; if (done_a !== 1'b0) $display("FAIL reset_done got=%b exp=0", done_a); else passed++;
    total++; if (pass_a !== 1'b0) $display("FAIL reset_pass got=%b exp=0", pass_a); else passed++;
    total++; if (err_a !== 8'h0) $display("FAIL reset_err got=%h exp=0", err_a); else passed++;
    total++; if (el_a !== 4'h0) $display("FAIL reset_err_lane got=%h exp=0", el_a); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_loopback();
    int bn, sb; logic [3:0] fs, fel; logic fd; logic [7:0] fe; bit to;
    noise_en_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      noise_a = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    total++; if ({err_a, el_a} !== 12'h0) $display("FAIL idle_noise err=%h lanes=%h exp=0", err_a, el_a); else passed++;
    noise_en_a = 1'b0;
    run_a(-1, -1, bn, fs, fd, fe, fel, sb, to);
    total++; if (to) $display("FAIL loop_timeout busy still high exp=low"); else passed++;
    total++; if (fs !== 4'h1) $display("FAIL loop_first_so got=%h exp=1", fs); else passed++;
    total++; if (bn !== PL + HOPS) $display("FAIL loop_busy_cycles got=%0d exp=%0d", bn, PL + HOPS); else passed++;
    total++; if (sb !== 0) $display("FAIL loop_pattern got=%0d bad exp=0", sb); else passed++;
    total++; if (done_a !== 1'b1) $display("FAIL loop_done got=%b exp=1", done_a); else passed++;
    total++; if (pass_a !== 1'b1) $display("FAIL loop_pass got=%b exp=1", pass_a); else passed++;
    total++; if ({err_a, el_a} !== 12'h0) $display("FAIL loop_errors err=%h lanes=%h exp=0", err_a, el_a); else passed++;
  endtask

  task automatic test_stuck_lane();
    int bn, sb, cnt; logic [3:0] fs, fel, lanes; logic fd; logic [7:0] fe; bit to;
    int lane_sel [2];
    lane_sel[0] = 2;
    lane_sel[1] = $urandom_range(0, 3);
    for (int j = 0; j < 2; j++) begin
      stuck_a = 4'(1 << lane_sel[j]);
      run_a(-1, -1, bn, fs, fd, fe, fel, sb, to);
      model(PL, 0, stuck_a, 4'h0, 8, cnt, lanes);
      total++; if (done_a !== !to) $display("FAIL stuck_done lane=%0d got=%b exp=1", lane_sel[j], done_a); else passed++;
      total++; if (el_a !== lanes) $display("FAIL stuck_err_lane lane=%0d got=%h exp=%h", lane_sel[j], el_a, lanes); else passed++;
      total++; if (err_a !== 8'(cnt)) $display("FAIL stuck_err_count lane=%0d got=%0d exp=%0d", lane_sel[j], err_a, cnt); else passed++;
      total++; if (pass_a !== (cnt == 0)) $display("FAIL stuck_pass lane=%0d got=%b exp=%b", lane_sel[j], pass_a, cnt == 0); else passed++;
    end
    stuck_a = 4'h0;
  endtask

  task automatic test_delay4();
    int bn, sb, cnt; logic [3:0] fs, fel, lanes; logic fd; logic [7:0] fe; bit to;
    dly_a = HOPS + 1;
    run_a(-1, -1, bn, fs, fd, fe, fel, sb, to);
    model(PL, 1, 4'h0, 4'h0, 8, cnt, lanes);
    total++; if (err_a !== 8'(cnt)) $display("FAIL delay4_err_count got=%0d exp=%0d", err_a, cnt); else passed++;
    total++; if (el_a !== lanes) $display("FAIL delay4_err_lane got=%h exp=%h", el_a, lanes); else passed++;
    total++; if (pass_a !== (cnt == 0)) $display("FAIL delay4_pass got=%b exp=%b", pass_a, cnt == 0); else passed++;
    dly_a = HOPS;
  endtask

  task automatic test_saturate();
    int cnt, guard; logic [3:0] lanes;
    @(negedge clk);
    go_b = 1'b1;
    @(negedge clk);
    go_b  = 1'b0;
    guard = 0;
    while (!done_b && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    model(PL, 0, 4'h0, 4'hF, 2, cnt, lanes);
    total++; if (done_b !== 1'b1) $display("FAIL sat_done got=%b exp=1", done_b); else passed++;
    total++; if (err_b !== 2'(cnt)) $display("FAIL sat_err_count got=%0d exp=%0d", err_b, cnt); else passed++;
    total++; if (el_b !== lanes) $display("FAIL sat_err_lane got=%h exp=%h", el_b, lanes); else passed++;
    total++; if (pass_b !== 1'b0) $display("FAIL sat_pass got=%b exp=0", pass_b); else passed++;
  endtask

  task automatic test_reset_midrun();
    int bn, sb, cnt; logic [3:0] fs, fel, lanes; logic fd; logic [7:0] fe; bit to;
    stuck_a = 4'h1;
    @(negedge clk);
    go_a = 1'b1;
    @(negedge clk);
    go_a = 1'b0;
    repeat (5) @(negedge clk);
    model(2, 0, stuck_a, 4'h0, 8, cnt, lanes);
    total++; if (err_a !== 8'(cnt)) $display("FAIL midrun_partial_err got=%0d exp=%0d", err_a, cnt); else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++; if (so_a !== 4'h0) $display("FAIL midrun_rst_start_out got=%h exp=0", so_a); else passed++;
    total++; if (busy_a !== 1'b0) $display("FAIL midrun_rst_busy got=%b exp=0", busy_a); else passed++;
    total++; if ({err_a, el_a} !== 12'h0) $display("FAIL midrun_rst_errors err=%h lanes=%h exp=0", err_a, el_a); else passed++;
    @(negedge clk);
    rst     = 1'b0;
    stuck_a = 4'h0;
    run_a(-1, -1, bn, fs, fd, fe, fel, sb, to);
    total++; if (fs !== 4'h1) $display("FAIL midrun_restart_first_so got=%h exp=1", fs); else passed++;
    total++; if (pass_a !== 1'b1) $display("FAIL midrun_restart_pass got=%b exp=1", pass_a); else passed++;
  endtask

  task automatic test_back_to_back();
    int bn, sb, cnt; logic [3:0] fs, fel, lanes; logic fd; logic [7:0] fe; bit to;
    run_a($urandom_range(1, PL - 1), $urandom_range(PL, PL + HOPS - 1), bn, fs, fd, fe, fel, sb, to);
    total++; if (bn !== PL + HOPS) $display("FAIL ignore_go_busy got=%0d exp=%0d", bn, PL + HOPS); else passed++;
    total++; if (sb !== 0) $display("FAIL ignore_go_pattern got=%0d bad exp=0", sb); else passed++;
    total++; if (pass_a !== 1'b1) $display("FAIL ignore_go_pass got=%b exp=1", pass_a); else passed++;
    stuck_a = 4'(1 << $urandom_range(0, 3));
    run_a(-1, -1, bn, fs, fd, fe, fel, sb, to);
    model(PL, 0, stuck_a, 4'h0, 8, cnt, lanes);
    total++; if (err_a !== 8'(cnt)) $display("FAIL b2b_fault_err got=%0d exp=%0d", err_a, cnt); else passed++;
    stuck_a = 4'h0;
    run_a(-1, -1, bn, fs, fd, fe, fel, sb, to);
    total++; if (fd !== 1'b0) $display("FAIL b2b_done_drop got=%b exp=0", fd); else passed++;
    total++; if ({fe, fel} !== 12'h0) $display("FAIL b2b_clear err=%h lanes=%h exp=0", fe, fel); else passed++;
    total++; if (fs !== 4'h1) $display("FAIL b2b_first_so got=%h exp=1", fs); else passed++;
    total++; if (pass_a !== 1'b1) $display("FAIL b2b_pass got=%b exp=1", pass_a); else passed++;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_stuck_lane();
    test_delay4();
    test_saturate();
    test_reset_midrun();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
